fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding decode: owns the PC and issues req/ack reads to instruction memory.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues req/ack reads to
//               instruction memory and drives the IF/ID register, with a
//               one-entry skid buffer for decode stalls and redirect flushing.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4
);

    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_hold  = 2'd1;
    localparam logic [1:0] c_st_drop  = 2'd2;

    logic [1:0]  r_state, w_state_nx;
    logic        r_started;
    logic [31:0] r_pc, w_pc_nx;
    logic [31:0] r_drop_addr, w_drop_addr_nx;
    logic [31:0] r_skid_instr, w_skid_instr_nx;
    logic [31:0] r_skid_pc, w_skid_pc_nx;
    logic        r_if_valid, w_if_valid_nx;
    logic [31:0] r_if_instr, w_if_instr_nx;
    logic [31:0] r_if_pc, w_if_pc_nx;
    logic [31:0] r_if_pcplus4, w_if_pcplus4_nx;

    logic        w_req;
    logic        w_ack;
    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    // Request is held low until the first edge after reset release.
    assign w_req      = r_started && (r_state != c_st_hold);
    assign w_ack      = imem_ack && w_req;
    assign w_accept   = !stall || !r_if_valid;
    assign w_target   = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem_req   = w_req;
    assign imem_addr  = (r_state == c_st_drop) ? r_drop_addr : r_pc;
    assign if_valid   = r_if_valid;
    assign if_instr   = r_if_instr;
    assign if_pc      = r_if_pc;
    assign if_pcplus4 = r_if_pcplus4;

    always_comb begin
        w_state_nx       = r_state;
        w_pc_nx          = r_pc;
        w_drop_addr_nx   = r_drop_addr;
        w_skid_instr_nx  = r_skid_instr;
        w_skid_pc_nx     = r_skid_pc;
        w_if_valid_nx    = r_if_valid;
        w_if_instr_nx    = r_if_instr;
        w_if_pc_nx       = r_if_pc;
        w_if_pcplus4_nx  = r_if_pcplus4;

        if (redirect) begin
            w_if_valid_nx = 1'b0;
            w_if_instr_nx = 32'h0;
            w_pc_nx       = w_target;
            case (r_state)
                c_st_fetch: begin
                    // An unanswered request must still be retired before refetching.
                    if (w_req && !w_ack) begin
                        w_state_nx     = c_st_drop;
                        w_drop_addr_nx = r_pc;
                    end
                end
                c_st_hold: w_state_nx = c_st_fetch;
                c_st_drop: if (w_ack) w_state_nx = c_st_fetch;
                default:   w_state_nx = c_st_fetch;
            endcase
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (w_ack) begin
                        w_pc_nx = w_pc_plus4;
                        if (w_accept) begin
                            w_if_valid_nx   = 1'b1;
                            w_if_instr_nx   = imem_rdata;
                            w_if_pc_nx      = r_pc;
                            w_if_pcplus4_nx = w_pc_plus4;
                        end else begin
                            w_skid_instr_nx = imem_rdata;
                            w_skid_pc_nx    = r_pc;
                            w_state_nx      = c_st_hold;
                        end
                    end else if (!stall) begin
                        w_if_valid_nx = 1'b0;
                        w_if_instr_nx = 32'h0;
                    end
                end
                c_st_hold: begin
                    if (!stall) begin
                        w_if_valid_nx   = 1'b1;
                        w_if_instr_nx   = r_skid_instr;
                        w_if_pc_nx      = r_skid_pc;
                        w_if_pcplus4_nx = r_skid_pc + 32'd4;
                        w_state_nx      = c_st_fetch;
                    end
                end
                c_st_drop: if (w_ack) w_state_nx = c_st_fetch;
                default:   w_state_nx = c_st_fetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_fetch;
            r_started    <= 1'b0;
            r_pc         <= RESET_PC;
            r_drop_addr  <= 32'h0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'h0;
            r_if_pc      <= 32'h0;
            r_if_pcplus4 <= 32'h0;
        end else begin
            r_state      <= w_state_nx;
            r_started    <= 1'b1;
            r_pc         <= w_pc_nx;
            r_drop_addr  <= w_drop_addr_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
            r_if_valid   <= w_if_valid_nx;
            r_if_instr   <= w_if_instr_nx;
            r_if_pc      <= w_if_pc_nx;
            r_if_pcplus4 <= w_if_pcplus4_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed bench for fetch_unit: sequencing, delayed ack, stall
//               with skid, redirect/drop, PC wrap and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        r_reset_n = 1'b0;
    logic        r_ack = 1'b0;
    logic [31:0] r_rdata = 32'h0;
    logic        r_stall = 1'b0;
    logic        r_redirect = 1'b0;
    logic [31:0] r_redirect_pc = 32'h0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pcplus4;

    int passed = 0;
    int total  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (r_reset_n),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (r_ack),
        .imem_rdata  (r_rdata),
        .stall       (r_stall),
        .redirect    (r_redirect),
        .redirect_pc (r_redirect_pc),
        .if_valid    (w_if_valid),
        .if_instr    (w_if_instr),
        .if_pc       (w_if_pc),
        .if_pcplus4  (w_if_pcplus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'h0, w_if_valid}, 32'h1);
        chk({tag, "_pc"}, w_if_pc, pc);
        chk({tag, "_instr"}, w_if_instr, pc ^ c_key);
        chk({tag, "_pc4"}, w_if_pcplus4, pc + 32'd4);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, {31'h0, w_req}, 32'h0);
        chk({tag, "_addr"}, w_addr, 32'h0);
        chk({tag, "_valid"}, {31'h0, w_if_valid}, 32'h0);
        chk({tag, "_instr"}, w_if_instr, 32'h0);
        chk({tag, "_pc"}, w_if_pc, 32'h0);
        chk({tag, "_pc4"}, w_if_pcplus4, 32'h0);
    endtask

    task automatic do_reset();
        r_ack = 1'b0; r_stall = 1'b0; r_redirect = 1'b0;
        r_reset_n = 1'b0;
        tick();
        tick();
        r_reset_n = 1'b1;
        chk("rst_req_before_edge", {31'h0, w_req}, 32'h0);
        tick();
        chk("rst_first_req", {31'h0, w_req}, 32'h1);
        chk("rst_first_addr", w_addr, 32'h0);
    endtask

    initial begin
        #1;
        chk_zero("reset_state");
        do_reset();

        // T1: back-to-back fetch with ack every cycle
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", w_addr, 32'(4 * i));
            r_ack = 1'b1; r_rdata = 32'(4 * i) ^ c_key;
            tick();
            chk_ifid("t1", 32'(4 * i));
        end
        r_ack = 1'b0;

        // T2: ack for 0x4 delayed three cycles
        do_reset();
        r_ack = 1'b1; r_rdata = 32'h0 ^ c_key;
        tick();
        chk_ifid("t2_first", 32'h0);
        r_ack = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t2_req", {31'h0, w_req}, 32'h1);
            chk("t2_addr", w_addr, 32'h4);
            tick();
            chk("t2_valid_low", {31'h0, w_if_valid}, 32'h0);
            chk("t2_instr_nop", w_if_instr, 32'h0);
        end
        r_ack = 1'b1; r_rdata = 32'h4 ^ c_key;
        tick();
        chk_ifid("t2_late", 32'h4);

        // T3: stall with 0x8 in IF/ID while 0xC is acked
        chk("t3_addr8", w_addr, 32'h8);
        r_rdata = 32'h8 ^ c_key;
        tick();
        chk_ifid("t3_w8", 32'h8);
        chk("t3_addrc", w_addr, 32'hC);
        r_stall = 1'b1; r_rdata = 32'hC ^ c_key;
        tick();
        r_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_ifid("t3_hold", 32'h8);
            chk("t3_req_low", {31'h0, w_req}, 32'h0);
            if (k < 2) tick();
        end
        r_stall = 1'b0;
        tick();
        chk_ifid("t3_skid", 32'hC);
        chk("t3_addr10", w_addr, 32'h10);
        r_ack = 1'b1; r_rdata = 32'h10 ^ c_key;
        tick();
        chk_ifid("t3_after", 32'h10);
        r_ack = 1'b0;

        // T4: redirect to 0x103 while the 0x14 request is pending
        chk("t4_addr_pending", w_addr, 32'h14);
        r_redirect = 1'b1; r_redirect_pc = 32'h103;
        tick();
        r_redirect = 1'b0;
        chk("t4_valid_low", {31'h0, w_if_valid}, 32'h0);
        chk("t4_instr_nop", w_if_instr, 32'h0);
        chk("t4_drop_req", {31'h0, w_req}, 32'h1);
        chk("t4_drop_addr", w_addr, 32'h14);
        tick();
        chk("t4_drop_addr2", w_addr, 32'h14);
        r_ack = 1'b1; r_rdata = 32'hDEAD_BEEF;
        tick();
        r_ack = 1'b0;
        chk("t4_dropped", {31'h0, w_if_valid}, 32'h0);
        chk("t4_new_addr", w_addr, 32'h100);
        r_ack = 1'b1; r_rdata = 32'h100 ^ c_key;
        tick();
        chk_ifid("t4_target", 32'h100);

        // T5: redirect, stall and ack in the same cycle
        r_stall = 1'b1; r_redirect = 1'b1; r_redirect_pc = 32'h40; r_rdata = 32'h104 ^ c_key;
        tick();
        r_stall = 1'b0; r_redirect = 1'b0;
        chk("t5_valid_low", {31'h0, w_if_valid}, 32'h0);
        chk("t5_instr_nop", w_if_instr, 32'h0);
        chk("t5_addr", w_addr, 32'h40);
        r_rdata = 32'h40 ^ c_key;
        tick();
        chk_ifid("t5_target", 32'h40);
        r_ack = 1'b0;

        // PC wrap at the top of the address space
        r_redirect = 1'b1; r_redirect_pc = 32'hFFFF_FFFE;
        tick();
        r_redirect = 1'b0;
        r_ack = 1'b1; r_rdata = 32'h0;
        tick();
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        r_rdata = 32'hFFFF_FFFC ^ c_key;
        tick();
        r_ack = 1'b0;
        chk_ifid("wrap", 32'hFFFF_FFFC);
        chk("wrap_next_addr", w_addr, 32'h0);

        // T6: async reset mid-request, then while stalled in HOLD
        r_reset_n = 1'b0;
        #1;
        chk_zero("t6_midreq");
        #2;
        r_reset_n = 1'b1;
        tick();
        chk("t6_restart_addr", w_addr, 32'h0);
        chk("t6_restart_req", {31'h0, w_req}, 32'h1);
        r_ack = 1'b1; r_rdata = 32'h0 ^ c_key;
        tick();
        r_stall = 1'b1; r_rdata = 32'h4 ^ c_key;
        tick();
        r_ack = 1'b0;
        chk("t6_in_hold", {31'h0, w_req}, 32'h0);
        r_reset_n = 1'b0;
        #1;
        chk_zero("t6_stalled");
        r_stall = 1'b0;
        #2;
        r_reset_n = 1'b1;
        tick();
        chk("t6_restart2_addr", w_addr, 32'h0);
        chk("t6_restart2_req", {31'h0, w_req}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
